// File: rtl/video_pattern_gen.sv
// -----------------------------------------------------------------------------
// video_pattern_gen
//
// Synthetic video source for the Sobel edge-detection path. Generates
// hsync/vsync/de timing and a 24-bit RGB test pattern on the same pixel bus
// the edge detector consumes, so the edge stage can run on hardware without
// an external video input.
//
// Ports
//   clk          pixel clock
//   rst          asynchronous, active-high reset
//   en           run enable; low returns the raster to (0,0) and idles the
//                outputs, high restarts at pixel (0,0)
//   pattern_sel  0 colour bars, 1 checkerboard, 2 grey ramp, 3 bouncing square;
//                sampled only on the cycle that produces pixel (0,0)
//   red_o, green_o, blue_o   8-bit pixel data, zero outside the active area
//   hsync_out, vsync_out     sync pulses, asserted level SYNC_POL
//   de_out                   data enable, high inside the active area
//   frame_start              one-cycle pulse coincident with pixel (0,0)
//
// Every output is registered and describes the raster position that the
// same clock edge processes.
// -----------------------------------------------------------------------------
module video_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] pattern_sel,
  output logic [7:0] red_o,
  output logic [7:0] green_o,
  output logic [7:0] blue_o,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       de_out,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_ACT_C    = 12'(H_ACTIVE);
  localparam logic [11:0] H_LAST_C   = 12'(H_TOTAL - 1);
  localparam logic [11:0] HS_BEG_C   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END_C   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_ACT_C    = 12'(V_ACTIVE);
  localparam logic [11:0] V_LAST_C   = 12'(V_TOTAL - 1);
  localparam logic [11:0] VS_BEG_C   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END_C   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] BAR_LAST_C = 12'(H_ACTIVE / 8 - 1);
  localparam logic [11:0] SQ_X_MAX_C = 12'(H_ACTIVE - 32);
  localparam logic [11:0] SQ_Y_MAX_C = 12'(V_ACTIVE - 32);
  localparam logic        SYNC_ON    = (SYNC_POL != 0);

  // Bar index advance, pinned at the last (black) bar so that the
  // H_ACTIVE % 8 remainder pixels stay black.
  function automatic logic [2:0] bar_inc_sat(input logic [2:0] idx);
    return (idx == 3'd7) ? 3'd7 : idx + 3'd1;
  endfunction

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  // One bounce step on one axis; returns {dir, pos}, dir = 1 means increasing.
  // With no room to move (active size exactly 32) the square is held at 0
  // instead of stepping outside the picture.
  function automatic logic [12:0] bounce_step(input logic [11:0] pos,
                                              input logic        dir,
                                              input logic [11:0] lim);
    logic [11:0] p;
    logic        d;
    p = pos;
    d = dir;
    if (lim == 12'd0) begin
      p = 12'd0;
    end else if (dir && (pos == lim)) begin
      d = 1'b0;
      p = pos - 12'd1;
    end else if (!dir && (pos == 12'd0)) begin
      d = 1'b1;
      p = pos + 12'd1;
    end else if (dir) begin
      p = pos + 12'd1;
    end else begin
      p = pos - 12'd1;
    end
    return {d, p};
  endfunction

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic [1:0]  pat_q;
  logic [2:0]  bar_idx;
  logic [11:0] bar_cnt;
  logic [11:0] sq_x;
  logic [11:0] sq_y;
  logic        dx;
  logic        dy;

  logic        first_px;
  logic        h_last;
  logic        v_last;
  logic        active;
  logic        hs_now;
  logic        vs_now;
  logic        in_sq;
  logic [1:0]  pat_cur;
  logic [2:0]  bar_idx_cur;
  logic [11:0] bar_cnt_cur;
  logic [2:0]  bar_idx_nxt;
  logic [11:0] bar_cnt_nxt;
  logic [11:0] sq_x_end;
  logic [11:0] sq_y_end;
  logic [12:0] x_step;
  logic [12:0] y_step;
  logic [23:0] rgb_nxt;

  always_comb begin
    first_px = (h_cnt == 12'd0) && (v_cnt == 12'd0);
    h_last   = (h_cnt == H_LAST_C);
    v_last   = (v_cnt == V_LAST_C);
    active   = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    hs_now   = (h_cnt >= HS_BEG_C) && (h_cnt < HS_END_C);
    vs_now   = (v_cnt >= VS_BEG_C) && (v_cnt < VS_END_C);

    // The pixel that latches pattern_sel is already drawn with the new value.
    pat_cur = first_px ? pattern_sel : pat_q;

    // Bar tracking restarts at x = 0; the registered state holds the values
    // for the current h_cnt on every other pixel of the line.
    bar_idx_cur = (h_cnt == 12'd0) ? 3'd0 : bar_idx;
    bar_cnt_cur = (h_cnt == 12'd0) ? 12'd0 : bar_cnt;
    if (bar_cnt_cur == BAR_LAST_C) begin
      bar_idx_nxt = bar_inc_sat(bar_idx_cur);
      bar_cnt_nxt = 12'd0;
    end else begin
      bar_idx_nxt = bar_idx_cur;
      bar_cnt_nxt = bar_cnt_cur + 12'd1;
    end

    sq_x_end = sq_x + 12'd32;
    sq_y_end = sq_y + 12'd32;
    in_sq    = (h_cnt >= sq_x) && (h_cnt < sq_x_end) &&
               (v_cnt >= sq_y) && (v_cnt < sq_y_end);

    x_step = bounce_step(sq_x, dx, SQ_X_MAX_C);
    y_step = bounce_step(sq_y, dy, SQ_Y_MAX_C);

    rgb_nxt = 24'h000000;
    if (active) begin
      case (pat_cur)
        2'd0:    rgb_nxt = bar_colour(bar_idx_cur);
        2'd1:    rgb_nxt = (h_cnt[4] ^ v_cnt[4]) ? 24'hFFFFFF : 24'h000000;
        2'd2:    rgb_nxt = {h_cnt[7:0], h_cnt[7:0], h_cnt[7:0]};
        default: rgb_nxt = in_sq ? 24'hFFFFFF : 24'h000000;
      endcase
    end
  end

  // Stage p0: raster counters, pattern state and registered pixel bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt       <= 12'd0;
      v_cnt       <= 12'd0;
      pat_q       <= 2'd0;
      bar_idx     <= 3'd0;
      bar_cnt     <= 12'd0;
      sq_x        <= 12'd0;
      sq_y        <= 12'd0;
      dx          <= 1'b1;
      dy          <= 1'b1;
      red_o       <= 8'd0;
      green_o     <= 8'd0;
      blue_o      <= 8'd0;
      hsync_out   <= !SYNC_ON;
      vsync_out   <= !SYNC_ON;
      de_out      <= 1'b0;
      frame_start <= 1'b0;
    end else if (!en) begin
      // Idle: park the raster at (0,0); the square keeps its place.
      h_cnt       <= 12'd0;
      v_cnt       <= 12'd0;
      bar_idx     <= 3'd0;
      bar_cnt     <= 12'd0;
      red_o       <= 8'd0;
      green_o     <= 8'd0;
      blue_o      <= 8'd0;
      hsync_out   <= !SYNC_ON;
      vsync_out   <= !SYNC_ON;
      de_out      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_cnt <= h_last ? 12'd0 : h_cnt + 12'd1;
      if (h_last) begin
        v_cnt <= v_last ? 12'd0 : v_cnt + 12'd1;
      end
      if (first_px) begin
        pat_q <= pattern_sel;
      end
      bar_idx <= bar_idx_nxt;
      bar_cnt <= bar_cnt_nxt;
      // The square moves once per frame, on the last raster position.
      if (h_last && v_last) begin
        dx   <= x_step[12];
        sq_x <= x_step[11:0];
        dy   <= y_step[12];
        sq_y <= y_step[11:0];
      end
      red_o       <= rgb_nxt[23:16];
      green_o     <= rgb_nxt[15:8];
      blue_o      <= rgb_nxt[7:0];
      hsync_out   <= hs_now ? SYNC_ON : !SYNC_ON;
      vsync_out   <= vs_now ? SYNC_ON : !SYNC_ON;
      de_out      <= active;
      frame_start <= first_px;
    end
  end

endmodule
